ped_request_conditioner: RTL and testbench

- Upstream of `traffic_light_control`; drives its `x` pedestrian-request input.
- Synchronises and debounces the raw crossing push-button, then latches one clean request.
- Holds `x` high until the controller grants `walk`.
- Enforces a lockout after each walk phase, remembering a press made during lockout.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/button_debounce.sv | 59 +++++
 rtl/ped_request_conditioner.sv | 124 ++++++++++++
 tb/tb_ped_request_conditioner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ============================================================================
// traffic_pkg
//   Shared types and constants for the pedestrian request path.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef enum logic [1:0] {
    PR_IDLE    = 2'd0,
    PR_PENDING = 2'd1,
    PR_SERVING = 2'd2,
    PR_LOCKOUT = 2'd3
  } pr_state_e;

  localparam logic [7:0] ACCEPT_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce
//   Synchronises a raw push-button and accepts a level after it holds steady.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic deb,
  output logic press
);

  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   deb_q, deb_d;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised level agrees with deb restarts the count.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s != deb_q) begin
      if (dcnt_q == DCNT_LAST) begin
        deb_d = s;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign press = deb_d & ~deb_q;
  assign deb   = deb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ped_request_conditioner.sv
// ============================================================================
// ped_request_conditioner
//   Turns debounced button presses into a held request with post-walk lockout.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module ped_request_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       walk,
  output logic       x,
  output logic       pending,
  output logic [7:0] accept_count
);

  localparam logic [CNT_W-1:0] LCNT_INIT = CNT_W'(LOCKOUT_CYCLES - 1);

  pr_state_e        state_q, state_d;
  logic             memo_q, memo_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             x_q, pending_q;
  logic [7:0]       accept_count_q, accept_count_d;
  logic             deb_w, press_w, press;
  logic             count_inc;

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .button_raw(button_raw),
    .deb       (deb_w),
    .press     (press_w)
  );

  // A press is only a rising edge, so the accepted level is still low here.
  assign press = press_w & ~deb_w;

  always_comb begin
    state_d   = state_q;
    memo_d    = memo_q;
    lcnt_d    = lcnt_q;
    count_inc = 1'b0;
    case (state_q)
      PR_IDLE: begin
        if (walk) begin
          state_d = PR_SERVING;
        end else if (press) begin
          state_d   = PR_PENDING;
          count_inc = 1'b1;
        end
      end
      PR_PENDING: begin
        if (walk) state_d = PR_SERVING;
      end
      PR_SERVING: begin
        if (!walk) begin
          state_d = PR_LOCKOUT;
          lcnt_d  = LCNT_INIT;
          memo_d  = 1'b0;
        end
      end
      PR_LOCKOUT: begin
        if (walk) begin
          state_d = PR_SERVING;
          memo_d  = 1'b0;
        end else begin
          if (press && !memo_q) begin
            memo_d    = 1'b1;
            count_inc = 1'b1;
          end
          if (lcnt_q == '0) begin
            state_d = (memo_q || press) ? PR_PENDING : PR_IDLE;
            memo_d  = 1'b0;
          end else begin
            lcnt_d = lcnt_q - 1'b1;
          end
        end
      end
      default: state_d = PR_IDLE;
    endcase

    accept_count_d = accept_count_q;
    if (count_inc && (accept_count_q != ACCEPT_MAX)) begin
      accept_count_d = accept_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= PR_IDLE;
      memo_q         <= 1'b0;
      lcnt_q         <= '0;
      x_q            <= 1'b0;
      pending_q      <= 1'b0;
      accept_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      memo_q         <= memo_d;
      lcnt_q         <= lcnt_d;
      x_q            <= (state_d == PR_PENDING);
      pending_q      <= (state_d == PR_PENDING) || ((state_d == PR_LOCKOUT) && memo_d);
      accept_count_q <= accept_count_d;
    end
  end

  assign x            = x_q;
  assign pending      = pending_q;
  assign accept_count = accept_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ped_request_conditioner.sv
// ============================================================================
// tb_ped_request_conditioner
//   Scoreboard bench: expected outputs are queued per edge and compared on arrival.
//   Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ped_request_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_raw;
  logic       walk;
  logic       x;
  logic       pending;
  logic [7:0] accept_count;

  typedef struct {
    int         cyc;
    logic       x;
    logic       p;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t ent;
  int   checks = 0;
  int   errors = 0;

  ped_request_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .button_raw  (button_raw),
    .walk        (walk),
    .x           (x),
    .pending     (pending),
    .accept_count(accept_count)
  );

  always #50 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  function automatic void expect_at(int cyc, logic ex, logic ep, logic [7:0] ec);
    exp_t t;
    t.cyc = cyc;
    t.x   = ex;
    t.p   = ep;
    t.c   = ec;
    sb.push_back(t);
  endfunction

  // Leaves reset released just after an edge, so the next edge is edge 1.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; button_raw = 1'b0; walk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({x, pending, accept_count} !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold: x=%b pending=%b count=%0d, expected all 0", x, pending, accept_count);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x, pending, accept_count} !== 10'd0) begin
      errors++;
      $display("FAIL reset_idle: x=%b pending=%b count=%0d, expected all 0", x, pending, accept_count);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    expect_at(5, 0, 0, 1'd0); expect_at(6, 1, 1, 8'd1); expect_at(11, 1, 1, 8'd1);
    expect_at(12, 0, 0, 8'd1); expect_at(21, 0, 0, 8'd1);
    button_raw = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL clean_press edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
      if (e == 10) button_raw = 1'b0;
      walk = (e == 11);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    expect_at(10, 0, 0, 8'd0); expect_at(20, 0, 0, 8'd0); expect_at(30, 0, 0, 8'd0);
    button_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL glitch edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
      button_raw = ((e % 5) < 3) && (e < 25);
    end
  endtask

  task automatic test_redundant();
    do_reset();
    expect_at(6, 1, 1, 8'd1); expect_at(30, 1, 1, 8'd1); expect_at(50, 1, 1, 8'd1);
    expect_at(70, 1, 1, 8'd1); expect_at(76, 1, 1, 8'd1);
    button_raw = 1'b1;
    for (int e = 1; e <= 76; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL redundant edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
      button_raw = ((e / 10) % 2 == 0);
    end
  endtask

  // walk sampled high on edges 1..4, low at edge k=5; press lands at k+3.
  task automatic test_lockout_memo();
    do_reset();
    expect_at(4, 0, 0, 8'd0); expect_at(7, 0, 0, 8'd0); expect_at(8, 0, 1, 8'd1);
    expect_at(12, 0, 1, 8'd1); expect_at(13, 1, 1, 8'd1);
    walk = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL lockout_memo edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
      if (e == 4) walk = 1'b0;
      if (e == 2) button_raw = 1'b1;
    end
  endtask

  // Lockout ends at edge 13; a press landing at edge 14 must come from IDLE.
  task automatic test_lockout_expiry();
    do_reset();
    expect_at(8, 0, 0, 8'd0); expect_at(13, 0, 0, 8'd0); expect_at(14, 1, 1, 8'd1);
    walk = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL lockout_expiry edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
      if (e == 4) walk = 1'b0;
      if (e == 8) button_raw = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    expect_at(6, 1, 1, 8'd1); expect_at(7, 1, 1, 8'd1);
    button_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL async_reset_pre edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
    end
    #20 reset = 1'b1;
    #1;
    checks++;
    if ({x, pending, accept_count} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset_clear: x=%b pending=%b count=%0d, expected all 0", x, pending, accept_count);
    end
    #19 reset = 1'b0;
    expect_at(5, 0, 0, 8'd0); expect_at(6, 1, 1, 8'd1);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL async_reset_post edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
    end
  endtask

  // Press, serve, lockout, repeat: one accepted press per 20-edge round.
  task automatic test_saturation();
    do_reset();
    for (int n = 1; n <= 260; n++) begin
      expect_at((n - 1) * 20 + 19, 0, 0, (n < 255) ? 8'(n) : 8'd255);
    end
    button_raw = 1'b1;
    for (int e = 1; e <= 260 * 20; e++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == e) begin
        ent = sb.pop_front(); checks++;
        if ({x, pending, accept_count} !== {ent.x, ent.p, ent.c}) begin
          errors++;
          $display("FAIL saturation edge %0d: x=%b pending=%b count=%0d, expected x=%b pending=%b count=%0d",
                   e, x, pending, accept_count, ent.x, ent.p, ent.c);
        end
      end
      button_raw = (e % 20) < 7;
      walk       = (e % 20) == 8;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    button_raw = 1'b0;
    walk       = 1'b0;
    #100;
    test_reset();
    test_clean_press();
    test_glitch();
    test_redundant();
    test_lockout_memo();
    test_lockout_expiry();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
